// File: rtl/jump_control_vectored.sv
// ---------------------------------------------------------------------------
// jump_control_vectored
//
// Purpose:
//   Program-counter redirect unit. It resolves direct jumps (JMP, JZ, JC),
//   accepts vectored, priority-nested interrupts onto a small return stack,
//   and unwinds that stack on RETI. Every decision is taken from the inputs
//   sampled at one rising edge, and its outputs are registered from that
//   same edge, giving a one-cycle latency.
//
// Ports:
//   clk                in   single clock; all state changes on its rising edge
//   reset              in   synchronous, active-high reset
//   jmp_address_pm     in   jump target fetched from program memory
//   current_address    in   address of the instruction currently presented
//   op                 in   opcode (6'h18 JMP, 6'h1C JZ, 6'h1E JC, 6'h10 RETI)
//   flag_ex            in   execute flags: [1] carry, [0] zero
//   irq_req            in   level interrupt requests, index 0 = highest priority
//   irq_en             in   per-line interrupt enable mask
//   jmp_loc            out  registered redirect address
//   pc_mux_sel         out  registered; 1 selects jmp_loc as the next PC
//   irq_ack            out  one-hot, one-cycle acknowledge of the accepted line
//   flag_restore       out  flags popped by RETI
//   flag_restore_valid out  one-cycle pulse qualifying flag_restore
//   depth              out  current return-stack occupancy
//   stack_err          out  one-cycle pulse on RETI while the stack is empty
// ---------------------------------------------------------------------------
module jump_control_vectored #(
    parameter int                ADDR_W      = 16,
    parameter int                NUM_IRQ     = 4,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] VEC_BASE    = 16'hF000,
    parameter int                VEC_STRIDE  = 4,
    localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  jmp_address_pm,
    input  logic [ADDR_W-1:0]  current_address,
    input  logic [5:0]         op,
    input  logic [1:0]         flag_ex,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic [ADDR_W-1:0]  jmp_loc,
    output logic               pc_mux_sel,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [1:0]         flag_restore,
    output logic               flag_restore_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_err
);

    localparam logic [5:0] OP_JMP  = 6'h18;
    localparam logic [5:0] OP_JZ   = 6'h1C;
    localparam logic [5:0] OP_JC   = 6'h1E;
    localparam logic [5:0] OP_RETI = 6'h10;

    // Return stack: saved address, saved flags and the priority level that
    // was entered, one slot per nesting level.
    logic [ADDR_W-1:0]  r_stk_addr [STACK_DEPTH];
    logic [1:0]         r_stk_flag [STACK_DEPTH];
    logic [2:0]         r_stk_prio [STACK_DEPTH];
    logic [DEPTH_W-1:0] r_depth;

    logic [ADDR_W-1:0]  r_jmp_loc;
    logic               r_pc_mux_sel;
    logic [NUM_IRQ-1:0] r_irq_ack;
    logic [1:0]         r_flag_restore;
    logic               r_flag_restore_valid;
    logic               r_stack_err;

    logic [NUM_IRQ-1:0] w_elig;
    logic [2:0]         w_win_idx;
    logic               w_any;
    logic [DEPTH_W-1:0] w_top_idx;
    logic [2:0]         w_top_prio;
    logic [ADDR_W-1:0]  w_top_addr;
    logic [1:0]         w_top_flag;
    logic               w_is_reti;
    logic               w_accept;
    logic               w_pop;
    logic               w_err;
    logic               w_jump_taken;
    logic [ADDR_W-1:0]  w_vec_addr;

    // Priority encoder: scanning downward leaves the lowest eligible index.
    always_comb begin
        w_elig    = irq_req & irq_en;
        w_any     = |w_elig;
        w_win_idx = 3'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            w_win_idx = w_elig[k] ? 3'(k) : w_win_idx;
        end
    end

    // Top-of-stack read; only meaningful when the stack is non-empty.
    always_comb begin
        w_top_idx  = r_depth - DEPTH_W'(1);
        w_top_prio = 3'd0;
        w_top_addr = '0;
        w_top_flag = 2'b00;
        for (int k = 0; k < STACK_DEPTH; k++) begin
            w_top_prio = (w_top_idx == DEPTH_W'(k)) ? r_stk_prio[k] : w_top_prio;
            w_top_addr = (w_top_idx == DEPTH_W'(k)) ? r_stk_addr[k] : w_top_addr;
            w_top_flag = (w_top_idx == DEPTH_W'(k)) ? r_stk_flag[k] : w_top_flag;
        end
    end

    // Conditional-jump resolution from the opcode and execute flags.
    always_comb begin
        w_jump_taken = 1'b0;
        case (op)
            OP_JMP:  w_jump_taken = 1'b1;
            OP_JZ:   w_jump_taken = flag_ex[0];
            OP_JC:   w_jump_taken = flag_ex[1];
            default: w_jump_taken = 1'b0;
        endcase
    end

    // Decision arbitration. An interrupt is never taken in a RETI cycle, so
    // a pending request is re-judged next cycle against the popped level.
    // Guarding push with the room check and pop with the empty check keeps
    // depth inside 0..STACK_DEPTH without wrapping.
    always_comb begin
        w_is_reti  = (op == OP_RETI);
        w_accept   = w_any && !w_is_reti
                     && (r_depth < DEPTH_W'(STACK_DEPTH))
                     && ((r_depth == DEPTH_W'(0)) || (w_win_idx < w_top_prio));
        w_pop      = w_is_reti && (r_depth != DEPTH_W'(0));
        w_err      = w_is_reti && (r_depth == DEPTH_W'(0));
        w_vec_addr = VEC_BASE + (ADDR_W'(w_win_idx) * ADDR_W'(VEC_STRIDE));
    end

    // State and registered outputs. Accept outranks a coincident jump: the
    // jump is dropped and its own address is saved so it re-executes later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth              <= '0;
            r_jmp_loc            <= '0;
            r_pc_mux_sel         <= 1'b0;
            r_irq_ack            <= '0;
            r_flag_restore       <= 2'b00;
            r_flag_restore_valid <= 1'b0;
            r_stack_err          <= 1'b0;
            for (int k = 0; k < STACK_DEPTH; k++) begin
                r_stk_addr[k] <= '0;
                r_stk_flag[k] <= 2'b00;
                r_stk_prio[k] <= 3'd0;
            end
        end else begin
            r_pc_mux_sel         <= 1'b0;
            r_irq_ack            <= '0;
            r_flag_restore_valid <= 1'b0;
            r_stack_err          <= 1'b0;
            if (w_accept) begin
                for (int k = 0; k < STACK_DEPTH; k++) begin
                    if (r_depth == DEPTH_W'(k)) begin
                        r_stk_addr[k] <= current_address;
                        r_stk_flag[k] <= flag_ex;
                        r_stk_prio[k] <= w_win_idx;
                    end else begin
                        r_stk_addr[k] <= r_stk_addr[k];
                    end
                end
                r_depth      <= r_depth + DEPTH_W'(1);
                r_jmp_loc    <= w_vec_addr;
                r_pc_mux_sel <= 1'b1;
                r_irq_ack    <= NUM_IRQ'(1) << w_win_idx;
            end else if (w_pop) begin
                r_depth              <= r_depth - DEPTH_W'(1);
                r_jmp_loc            <= w_top_addr;
                r_pc_mux_sel         <= 1'b1;
                r_flag_restore       <= w_top_flag;
                r_flag_restore_valid <= 1'b1;
            end else if (w_err) begin
                r_stack_err <= 1'b1;
            end else if (w_jump_taken) begin
                r_jmp_loc    <= jmp_address_pm;
                r_pc_mux_sel <= 1'b1;
            end else begin
                r_jmp_loc <= r_jmp_loc;
            end
        end
    end

    assign jmp_loc            = r_jmp_loc;
    assign pc_mux_sel         = r_pc_mux_sel;
    assign irq_ack            = r_irq_ack;
    assign flag_restore       = r_flag_restore;
    assign flag_restore_valid = r_flag_restore_valid;
    assign depth              = r_depth;
    assign stack_err          = r_stack_err;

endmodule

// File: tb/tb_jump_control_vectored.sv
// ---------------------------------------------------------------------------
// tb_jump_control_vectored
//
// Drives jump_control_vectored (two-entry return stack so the full-stack
// case is reachable) from a table of per-cycle records. Each record's
// expected outputs enter a scoreboard queue when its inputs are driven and
// are popped and compared one edge later, when the DUT has produced them.
// ---------------------------------------------------------------------------
module tb_jump_control_vectored;

    localparam logic [5:0] J  = 6'h18;
    localparam logic [5:0] JZ = 6'h1C;
    localparam logic [5:0] JC = 6'h1E;
    localparam logic [5:0] RT = 6'h10;
    localparam logic [5:0] NP = 6'h00;

    typedef struct {
        string       nm;
        logic        rst;
        logic [5:0]  op;
        logic [15:0] pm;
        logic [15:0] cur;
        logic [1:0]  flg;
        logic [3:0]  req;
        logic [3:0]  en;
        logic [15:0] e_loc;
        logic        e_sel;
        logic [3:0]  e_ack;
        logic [1:0]  e_fr;
        logic        e_frv;
        logic [1:0]  e_dep;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] jmp_address_pm;
    logic [15:0] current_address;
    logic [5:0]  op;
    logic [1:0]  flag_ex;
    logic [3:0]  irq_req;
    logic [3:0]  irq_en;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;
    logic [3:0]  irq_ack;
    logic [1:0]  flag_restore;
    logic        flag_restore_valid;
    logic [1:0]  depth;
    logic        stack_err;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    jump_control_vectored #(
        .ADDR_W(16), .NUM_IRQ(4), .STACK_DEPTH(2),
        .VEC_BASE(16'hF000), .VEC_STRIDE(4)
    ) dut (
        .clk(clk), .reset(reset),
        .jmp_address_pm(jmp_address_pm), .current_address(current_address),
        .op(op), .flag_ex(flag_ex), .irq_req(irq_req), .irq_en(irq_en),
        .jmp_loc(jmp_loc), .pc_mux_sel(pc_mux_sel), .irq_ack(irq_ack),
        .flag_restore(flag_restore), .flag_restore_valid(flag_restore_valid),
        .depth(depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic rst, logic [5:0] o, logic [15:0] pm,
                                logic [15:0] cur, logic [1:0] flg, logic [3:0] req,
                                logic [3:0] en, logic [15:0] loc, logic sel,
                                logic [3:0] ack, logic [1:0] fr, logic frv,
                                logic [1:0] dep, logic err);
        vec_t v;
        v.nm = nm; v.rst = rst; v.op = o; v.pm = pm; v.cur = cur; v.flg = flg;
        v.req = req; v.en = en; v.e_loc = loc; v.e_sel = sel; v.e_ack = ack;
        v.e_fr = fr; v.e_frv = frv; v.e_dep = dep; v.e_err = err;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        reset           = v.rst;
        op              = v.op;
        jmp_address_pm  = v.pm;
        current_address = v.cur;
        flag_ex         = v.flg;
        irq_req         = v.req;
        irq_en          = v.en;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", v.nm);
        end else begin
            e = exp_q.pop_front();
            if ({jmp_loc, pc_mux_sel, irq_ack, flag_restore, flag_restore_valid, depth, stack_err} !==
                {e.e_loc, e.e_sel, e.e_ack, e.e_fr, e.e_frv, e.e_dep, e.e_err}) begin
                failures++;
                $display("FAIL %s got loc=%h sel=%b ack=%b fr=%b frv=%b dep=%0d err=%b want loc=%h sel=%b ack=%b fr=%b frv=%b dep=%0d err=%b",
                         e.nm, jmp_loc, pc_mux_sel, irq_ack, flag_restore, flag_restore_valid, depth, stack_err,
                         e.e_loc, e.e_sel, e.e_ack, e.e_fr, e.e_frv, e.e_dep, e.e_err);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name        rst op  pm        cur       flg    req     en      loc       sel  ack     fr     frv  dep   err
        tbl.push_back(mk("rst0",  1, NP, 16'h0000, 16'h0000, 2'b00, 4'h0, 4'hF, 16'h0000, 0, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("rst1",  1, J,  16'h1111, 16'h0000, 2'b11, 4'hF, 4'hF, 16'h0000, 0, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("jmp",   0, J,  16'h0008, 16'h0000, 2'b00, 4'h0, 4'hF, 16'h0008, 1, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("jz_nt", 0, JZ, 16'h1234, 16'h0000, 2'b10, 4'h0, 4'hF, 16'h0008, 0, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("jc_t",  0, JC, 16'h0040, 16'h0000, 2'b10, 4'h0, 4'hF, 16'h0040, 1, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("jz_t",  0, JZ, 16'h0050, 16'h0000, 2'b01, 4'h0, 4'hF, 16'h0050, 1, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("nop",   0, NP, 16'h0077, 16'h0000, 2'b11, 4'h0, 4'hF, 16'h0050, 0, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("masked",0, J,  16'h0099, 16'h0000, 2'b00, 4'hF, 4'h0, 16'h0099, 1, 4'h0, 2'b00, 0, 2'd0, 0));
        tbl.push_back(mk("irq2",  0, NP, 16'h0000, 16'h0001, 2'b11, 4'h4, 4'hF, 16'hF008, 1, 4'h4, 2'b00, 0, 2'd1, 0));
        tbl.push_back(mk("irq2lv",0, NP, 16'h0000, 16'h0002, 2'b00, 4'h4, 4'hF, 16'hF008, 0, 4'h0, 2'b00, 0, 2'd1, 0));
        tbl.push_back(mk("nest0", 0, NP, 16'h0000, 16'h0005, 2'b00, 4'h5, 4'hF, 16'hF000, 1, 4'h1, 2'b00, 0, 2'd2, 0));
        tbl.push_back(mk("irq3bl",0, NP, 16'h0000, 16'h0006, 2'b00, 4'hD, 4'hF, 16'hF000, 0, 4'h0, 2'b00, 0, 2'd2, 0));
        tbl.push_back(mk("reti1", 0, RT, 16'h0000, 16'h0007, 2'b00, 4'hC, 4'hF, 16'h0005, 1, 4'h0, 2'b00, 1, 2'd1, 0));
        tbl.push_back(mk("irq3b2",0, NP, 16'h0000, 16'h0008, 2'b00, 4'hC, 4'hF, 16'h0005, 0, 4'h0, 2'b00, 0, 2'd1, 0));
        tbl.push_back(mk("reti2", 0, RT, 16'h0000, 16'h0009, 2'b00, 4'h8, 4'hF, 16'h0001, 1, 4'h0, 2'b11, 1, 2'd0, 0));
        tbl.push_back(mk("irq3ok",0, NP, 16'h0000, 16'h0010, 2'b01, 4'h8, 4'hF, 16'hF00C, 1, 4'h8, 2'b11, 0, 2'd1, 0));
        tbl.push_back(mk("reti3", 0, RT, 16'h0000, 16'h0011, 2'b00, 4'h0, 4'hF, 16'h0010, 1, 4'h0, 2'b01, 1, 2'd0, 0));
        tbl.push_back(mk("full_a",0, NP, 16'h0000, 16'h0020, 2'b00, 4'h8, 4'hF, 16'hF00C, 1, 4'h8, 2'b01, 0, 2'd1, 0));
        tbl.push_back(mk("full_b",0, NP, 16'h0000, 16'h0021, 2'b10, 4'hA, 4'hF, 16'hF004, 1, 4'h2, 2'b01, 0, 2'd2, 0));
        tbl.push_back(mk("full_c",0, NP, 16'h0000, 16'h0022, 2'b00, 4'hB, 4'hF, 16'hF004, 0, 4'h0, 2'b01, 0, 2'd2, 0));
        tbl.push_back(mk("full_r1",0,RT, 16'h0000, 16'h0023, 2'b00, 4'h0, 4'hF, 16'h0021, 1, 4'h0, 2'b10, 1, 2'd1, 0));
        tbl.push_back(mk("full_r2",0,RT, 16'h0000, 16'h0024, 2'b00, 4'h0, 4'hF, 16'h0020, 1, 4'h0, 2'b00, 1, 2'd0, 0));
        tbl.push_back(mk("empty", 0, RT, 16'h0000, 16'h0025, 2'b00, 4'h0, 4'hF, 16'h0020, 0, 4'h0, 2'b00, 0, 2'd0, 1));
        tbl.push_back(mk("col_j", 0, J,  16'h0300, 16'h0030, 2'b01, 4'h2, 4'hF, 16'hF004, 1, 4'h2, 2'b00, 0, 2'd1, 0));
        tbl.push_back(mk("col_r", 0, RT, 16'h0000, 16'h0031, 2'b00, 4'h2, 4'hF, 16'h0030, 1, 4'h0, 2'b01, 1, 2'd0, 0));
        tbl.push_back(mk("col_ak",0, NP, 16'h0000, 16'h0031, 2'b00, 4'h2, 4'hF, 16'hF004, 1, 4'h2, 2'b01, 0, 2'd1, 0));
        tbl.push_back(mk("col_id",0, NP, 16'h0000, 16'h0032, 2'b00, 4'h0, 4'hF, 16'hF004, 0, 4'h0, 2'b01, 0, 2'd1, 0));

        reset = 1'b1; op = NP; jmp_address_pm = 16'h0000; current_address = 16'h0000;
        flag_ex = 2'b00; irq_req = 4'h0; irq_en = 4'h0;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while two levels are nested, with a jump and an irq present.
        apply(mk("mid_d2", 0, NP, 16'h0000, 16'h0040, 2'b11, 4'h1, 4'hF, 16'hF000, 1, 4'h1, 2'b01, 0, 2'd2, 0));
        apply(mk("mid_rst",1, J,  16'h0555, 16'h0041, 2'b11, 4'h1, 4'hF, 16'h0000, 0, 4'h0, 2'b00, 0, 2'd0, 0));
        apply(mk("post_rt",0, RT, 16'h0000, 16'h0042, 2'b00, 4'h0, 4'hF, 16'h0000, 0, 4'h0, 2'b00, 0, 2'd0, 1));
        apply(mk("post_id",0, NP, 16'h0000, 16'h0043, 2'b00, 4'h0, 4'hF, 16'h0000, 0, 4'h0, 2'b00, 0, 2'd0, 0));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_control_vectored.md
JUMP_CONTROL_VECTORED -- requirements
Module: jump_control_vectored

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, 16, program-address width.
REQ-002 The block SHALL have parameter NUM_IRQ, 4, number of interrupt lines (1..8).
REQ-003 The block SHALL have parameter STACK_DEPTH, 4, return-stack entries (1..8).
REQ-004 The block SHALL have parameter VEC_BASE, 16'hF000, address of vector 0.
REQ-005 The block SHALL have parameter VEC_STRIDE, 4, address spacing between vectors.
Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, in, 1, synchronous, active-high reset.
REQ-008 The block SHALL have port jmp_address_pm, in, ADDR_W, jump target from program memory.
REQ-009 The block SHALL have port current_address, in, ADDR_W, address of the instruction currently presented.
REQ-010 The block SHALL have port op, in, 6, opcode: 6'h18 JMP, 6'h1C JZ, 6'h1E JC, 6'h10 RETI; all others are non-control.
REQ-011 The block SHALL have port flag_ex, in, 2, execute flags: [1] carry, [0] zero.
REQ-012 The block SHALL have port irq_req, in, NUM_IRQ, level interrupt requests; index 0 is highest priority.
REQ-013 The block SHALL have port irq_en, in, NUM_IRQ, per-line enable mask.
REQ-014 The block SHALL have port jmp_loc, out, ADDR_W, registered redirect address.
REQ-015 The block SHALL have port pc_mux_sel, out, 1, registered; 1 selects jmp_loc as the next PC.
REQ-016 The block SHALL have port irq_ack, out, NUM_IRQ, one-hot, one-cycle acknowledge of the accepted line.
REQ-017 The block SHALL have port flag_restore, out, 2, flags popped by RETI.
REQ-018 The block SHALL have port flag_restore_valid, out, 1, one-cycle pulse qualifying flag_restore.
REQ-019 The block SHALL have port depth, out, clog2(STACK_DEPTH+1), current stack occupancy.
REQ-020 The block SHALL have port stack_err, out, 1, one-cycle pulse on RETI issued while the stack is empty.

Function
REQ-021 Each decision SHALL be evaluated from the inputs sampled at edge N, and its outputs SHALL be valid after edge N (1-cycle latency); pc_mux_sel, irq_ack, flag_restore_valid and stack_err SHALL be 0 on every cycle without a redirect, accept or error.
REQ-022 JMP SHALL redirect unconditionally (jmp_loc=jmp_address_pm, pc_mux_sel=1).
REQ-023 JZ SHALL redirect only if flag_ex[0]=1, and JC only if flag_ex[1]=1; otherwise pc_mux_sel=0 and jmp_loc SHALL hold its previous value.
REQ-024 Eligible lines SHALL be irq_req & irq_en; the winner SHALL be the lowest eligible index i.
REQ-025 The winner SHALL be accepted only if depth<STACK_DEPTH and (depth=0 or i < the priority stored in the top-of-stack entry).
REQ-026 On accept, the block SHALL push {current_address, flag_ex, i}, increment depth, drive jmp_loc=VEC_BASE+i*VEC_STRIDE modulo 2^ADDR_W, pc_mux_sel=1 and irq_ack[i]=1.
REQ-027 RETI with depth>0 SHALL pop the top entry and drive jmp_loc=saved address, pc_mux_sel=1, flag_restore=saved flags and flag_restore_valid=1.
REQ-028 RETI with depth=0 SHALL produce no redirect and no state change, and SHALL pulse stack_err.
REQ-029 An accept coincident with JMP/JZ/JC SHALL win: the jump is discarded and current_address is saved, so the jump re-executes after RETI.
REQ-030 An accept SHALL NOT occur in a cycle where op=RETI; RETI executes and the interrupt is re-evaluated the next cycle against the popped level.
REQ-031 A non-preempting or stack-full request SHALL remain pending with no ack; the block SHALL NOT latch it (level sensitive).
REQ-032 The push and pop arithmetic SHALL never wrap: depth stays within 0..STACK_DEPTH.

Reset
REQ-033 While reset=1 at an edge, the block SHALL set depth=0, pc_mux_sel=0, jmp_loc=0, irq_ack=0, flag_restore=0, flag_restore_valid=0 and stack_err=0, and SHALL discard stack contents.
REQ-034 Reset SHALL override any simultaneous op or irq, including mid-nesting; the first decision SHALL come from the first edge with reset=0.

Verification
REQ-035 The bench SHALL check jumps: JMP with jmp_address_pm=16'h0008 -> next cycle jmp_loc=0008 and pc_mux_sel=1; JZ with flag_ex=2'b10 -> pc_mux_sel=0; JC with 2'b10 -> redirect.
REQ-036 The bench SHALL check an interrupt: irq_req=4'b0100, irq_en=4'hF, current_address=0x0001, flag_ex=2'b11 -> jmp_loc=F008, irq_ack=0100, depth=1; then RETI -> jmp_loc=0001, flag_restore=11, flag_restore_valid=1, depth=0.
REQ-037 The bench SHALL check nesting: line 2 in service, then line 0 raised -> jmp_loc=F000 and depth=2; line 3 raised during this -> no ack until both RETIs complete.
REQ-038 The bench SHALL check stack full: STACK_DEPTH=2 with lines 3, 1 and 0 raised in sequence -> the third request is not acked and depth stays 2; RETI at depth=0 -> stack_err pulse and pc_mux_sel=0.
REQ-039 The bench SHALL check collisions: JMP and irq 1 in the same cycle -> jmp_loc=F004 and saved address=current_address; RETI and irq in the same cycle -> RETI first, ack one cycle later.
REQ-040 The bench SHALL check reset mid-operation: reset asserted at depth=2 -> all outputs 0 and depth=0 next cycle; a RETI after reset -> stack_err.
